irq_ack_decoder_8: RTL and testbench

Acknowledge-side counterpart of the 8-line priority encoder. It accepts a 3-bit encoded request index through a valid/ready handshake and decodes it into a one-hot acknowledge pulse of programmable width on `ack[7:0]`. It also maintains a sticky 8-bit in-service mask that is set on acknowledge and cleared by end-of-interrupt strobes. It sits between the arbitration/priority-encoder stage and the eight requesting sources, returning per-source acknowledges and flagging duplicate service attempts.

---
 rtl/irq_ack_decoder_8_if.sv | 22 ++
 rtl/irq_ack_decoder_8.sv | 100 ++++++++++
 tb/tb_irq_ack_decoder_8.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/irq_ack_decoder_8_if.sv
// Handshake and status bundle between the priority-encoder stage and the
// acknowledge decoder; the decoder takes the slave side.
interface irq_ack_decoder_8_if;
  logic [2:0] code;
  logic       code_valid;
  logic       code_ready;
  logic [7:0] eoi;
  logic [7:0] ack;
  logic       ack_active;
  logic [7:0] in_service;
  logic       dup_err;

  modport master (
    output code, code_valid, eoi,
    input  code_ready, ack, ack_active, in_service, dup_err
  );

  modport slave (
    input  code, code_valid, eoi,
    output code_ready, ack, ack_active, in_service, dup_err
  );
endinterface

// File: rtl/irq_ack_decoder_8.sv
// Decodes an accepted 3-bit source index into a one-hot acknowledge pulse of
// ACK_CYCLES cycles and tracks a sticky in-service mask retired by eoi strobes.
module irq_ack_decoder_8 #(
  parameter int unsigned ACK_CYCLES = 2
) (
  input logic               clk,
  input logic               rst,
  irq_ack_decoder_8_if.slave bus
);

  localparam logic [3:0] LOAD_VALUE = 4'(ACK_CYCLES - 1);

  typedef enum logic {IDLE, ACK} state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] count;
  logic [3:0] count_next;
  logic [7:0] ack_q;
  logic [7:0] ack_next;
  logic       ack_active_q;
  logic [7:0] in_service_q;
  logic [7:0] set_mask;
  logic       dup_q;
  logic       dup_next;
  logic       ready;
  logic [7:0] busy;
  logic [7:0] code_onehot;
  logic       accept;
  logic       fresh;

  // A source whose eoi arrives in the accept cycle already counts as free.
  assign ready       = (state == IDLE) & ~rst;
  assign busy        = in_service_q & ~bus.eoi;
  assign code_onehot = 8'b1 << bus.code;
  assign accept      = bus.code_valid & ready;
  assign fresh       = accept & ~busy[bus.code];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      count        <= 4'd0;
      ack_q        <= 8'd0;
      ack_active_q <= 1'b0;
      in_service_q <= 8'd0;
      dup_q        <= 1'b0;
    end else begin
      state        <= state_next;
      count        <= count_next;
      ack_q        <= ack_next;
      ack_active_q <= |ack_next;
      in_service_q <= (in_service_q & ~bus.eoi) | set_mask;
      dup_q        <= dup_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fresh) state_next = ACK;
      ACK:     if (count == 4'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values for the registered outputs; a duplicate only raises dup_err.
  always_comb begin
    count_next = count;
    ack_next   = ack_q;
    set_mask   = 8'd0;
    dup_next   = accept & busy[bus.code];
    case (state)
      IDLE: begin
        if (fresh) begin
          ack_next   = code_onehot;
          set_mask   = code_onehot;
          count_next = LOAD_VALUE;
        end
      end
      ACK: begin
        if (count == 4'd0) begin
          ack_next = 8'd0;
        end else begin
          count_next = count - 4'd1;
        end
      end
      default: begin
        ack_next   = 8'd0;
        count_next = 4'd0;
      end
    endcase
  end

  assign bus.code_ready = ready;
  assign bus.ack        = ack_q;
  assign bus.ack_active = ack_active_q;
  assign bus.in_service = in_service_q;
  assign bus.dup_err    = dup_q;

endmodule

// File: tb/tb_irq_ack_decoder_8.sv
// Drives four decoders (ACK_CYCLES 1, 2, 4, 8) with one shared stimulus and
// compares every output against a pulse-countdown reference model.
module tb_irq_ack_decoder_8;

  logic       clk = 1'b0;
  logic       rst;
  logic       codeValid;
  logic [2:0] code;
  logic [7:0] eoi;

  int errors = 0;
  int checks = 0;

  irq_ack_decoder_8_if bus0 ();
  irq_ack_decoder_8_if bus1 ();
  irq_ack_decoder_8_if bus2 ();
  irq_ack_decoder_8_if bus3 ();

  irq_ack_decoder_8 #(.ACK_CYCLES(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  irq_ack_decoder_8 #(.ACK_CYCLES(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  irq_ack_decoder_8 #(.ACK_CYCLES(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  irq_ack_decoder_8 #(.ACK_CYCLES(8)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  assign bus0.code = code;  assign bus0.code_valid = codeValid;  assign bus0.eoi = eoi;
  assign bus1.code = code;  assign bus1.code_valid = codeValid;  assign bus1.eoi = eoi;
  assign bus2.code = code;  assign bus2.code_valid = codeValid;  assign bus2.eoi = eoi;
  assign bus3.code = code;  assign bus3.code_valid = codeValid;  assign bus3.eoi = eoi;

  logic [7:0] obsAck [4];
  logic [7:0] obsIns [4];
  logic       obsActive [4];
  logic       obsReady [4];
  logic       obsDup [4];

  assign obsAck[0] = bus0.ack;  assign obsIns[0] = bus0.in_service;
  assign obsAck[1] = bus1.ack;  assign obsIns[1] = bus1.in_service;
  assign obsAck[2] = bus2.ack;  assign obsIns[2] = bus2.in_service;
  assign obsAck[3] = bus3.ack;  assign obsIns[3] = bus3.in_service;
  assign obsActive[0] = bus0.ack_active;  assign obsReady[0] = bus0.code_ready;  assign obsDup[0] = bus0.dup_err;
  assign obsActive[1] = bus1.ack_active;  assign obsReady[1] = bus1.code_ready;  assign obsDup[1] = bus1.dup_err;
  assign obsActive[2] = bus2.ack_active;  assign obsReady[2] = bus2.code_ready;  assign obsDup[2] = bus2.dup_err;
  assign obsActive[3] = bus3.ack_active;  assign obsReady[3] = bus3.code_ready;  assign obsDup[3] = bus3.dup_err;

  always #5 clk = ~clk;

  // Reference model: cycles of acknowledge left, which source, sticky mask.
  int         ackCyc [4] = '{1, 2, 4, 8};
  int         remaining [4] = '{0, 0, 0, 0};
  logic [2:0] ackIdx [4] = '{3'd0, 3'd0, 3'd0, 3'd0};
  logic [7:0] mIns [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
  logic       mDup [4] = '{1'b0, 1'b0, 1'b0, 1'b0};

  task automatic modelEdge();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] setBits;
      setBits = 8'd0;
      if (rst) begin
        remaining[i] = 0;
        mIns[i]      = 8'd0;
        mDup[i]      = 1'b0;
      end else begin
        mDup[i] = 1'b0;
        if (remaining[i] == 0 && codeValid) begin
          if (mIns[i][code] && !eoi[code]) begin
            mDup[i] = 1'b1;
          end else begin
            ackIdx[i]    = code;
            remaining[i] = ackCyc[i];
            setBits[code] = 1'b1;
          end
        end else if (remaining[i] > 0) begin
          remaining[i] = remaining[i] - 1;
        end
        mIns[i] = (mIns[i] & ~eoi) | setBits;
      end
    end
  endtask

  task automatic checkValue(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] expAck;
      expAck = (remaining[i] > 0) ? (8'b1 << ackIdx[i]) : 8'd0;
      checkValue($sformatf("model ack inst%0d", i), obsAck[i], expAck);
      checkValue($sformatf("model in_service inst%0d", i), obsIns[i], mIns[i]);
      checkValue($sformatf("model ack_active inst%0d", i), {7'd0, obsActive[i]}, {7'd0, remaining[i] > 0});
      checkValue($sformatf("model dup_err inst%0d", i), {7'd0, obsDup[i]}, {7'd0, mDup[i]});
      checkValue($sformatf("model code_ready inst%0d", i), {7'd0, obsReady[i]},
                 {7'd0, (remaining[i] == 0) && !rst});
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] c, input logic [7:0] e);
    codeValid = v;
    code      = c;
    eoi       = e;
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    applyStimulus(1'b0, 3'd0, 8'd0);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 3'd0, 8'd0);
    step();
    step();
    checkValue("reset ack", obsAck[1], 8'h00);
    checkValue("reset in_service", obsIns[1], 8'h00);
    checkValue("reset code_ready", {7'd0, obsReady[1]}, 8'h00);
    rst = 1'b0;
    #1;
    checkValue("ready after reset", {7'd0, obsReady[1]}, 8'h01);

    // Accept code 5 with a two-cycle pulse
    applyStimulus(1'b1, 3'd5, 8'd0);
    step();
    checkValue("acc5 ack c1", obsAck[1], 8'h20);
    checkValue("acc5 in_service", obsIns[1], 8'h20);
    checkValue("acc5 ready c1", {7'd0, obsReady[1]}, 8'h00);
    applyStimulus(1'b0, 3'd0, 8'd0);
    step();
    checkValue("acc5 ack c2", obsAck[1], 8'h20);
    checkValue("acc5 ready c2", {7'd0, obsReady[1]}, 8'h00);
    step();
    checkValue("acc5 ack fall", obsAck[1], 8'h00);
    checkValue("acc5 ready c3", {7'd0, obsReady[1]}, 8'h01);
    idle(8);

    // Duplicate of code 5
    applyStimulus(1'b1, 3'd5, 8'd0);
    step();
    checkValue("dup dup_err", {7'd0, obsDup[1]}, 8'h01);
    checkValue("dup ack", obsAck[1], 8'h00);
    checkValue("dup in_service", obsIns[1], 8'h20);
    checkValue("dup ready", {7'd0, obsReady[1]}, 8'h01);
    applyStimulus(1'b0, 3'd0, 8'd0);
    step();
    checkValue("dup pulse end", {7'd0, obsDup[1]}, 8'h00);

    // Retire 5, service 3, then re-accept 3 alongside its own eoi
    applyStimulus(1'b0, 3'd0, 8'h20);
    step();
    applyStimulus(1'b1, 3'd3, 8'd0);
    step();
    idle(10);
    checkValue("eoi+acc pre mask", obsIns[1], 8'h08);
    applyStimulus(1'b1, 3'd3, 8'h08);
    step();
    checkValue("eoi+acc dup_err", {7'd0, obsDup[1]}, 8'h00);
    checkValue("eoi+acc ack", obsAck[1], 8'h08);
    checkValue("eoi+acc in_service", obsIns[1], 8'h08);
    idle(10);

    // Back-to-back stream on the single-cycle instance
    applyStimulus(1'b0, 3'd0, 8'hff);
    step();
    applyStimulus(1'b1, 3'd0, 8'd0);
    step();
    checkValue("stream ack0", obsAck[0], 8'h01);
    applyStimulus(1'b1, 3'd1, 8'd0);
    step();
    checkValue("stream gap0", obsAck[0], 8'h00);
    step();
    checkValue("stream ack1", obsAck[0], 8'h02);
    applyStimulus(1'b1, 3'd7, 8'd0);
    step();
    checkValue("stream gap1", obsAck[0], 8'h00);
    step();
    checkValue("stream ack7", obsAck[0], 8'h80);
    idle(1);
    checkValue("stream in_service", obsIns[0], 8'h83);
    idle(10);

    // Reset during the third cycle of an eight-cycle pulse
    applyStimulus(1'b1, 3'd2, 8'd0);
    step();
    checkValue("rstmid ack", obsAck[3], 8'h04);
    applyStimulus(1'b0, 3'd0, 8'd0);
    step();
    step();
    rst = 1'b1;
    step();
    checkValue("rstmid ack cleared", obsAck[3], 8'h00);
    checkValue("rstmid in_service", obsIns[3], 8'h00);
    checkValue("rstmid ack_active", {7'd0, obsActive[3]}, 8'h00);
    rst = 1'b0;
    step();
    checkValue("rstmid ready back", {7'd0, obsReady[3]}, 8'h01);

    // eoi on source 6 while its four-cycle pulse is running
    applyStimulus(1'b1, 3'd6, 8'd0);
    step();
    checkValue("eoiack ack c1", obsAck[2], 8'h40);
    checkValue("eoiack bit6 set", {7'd0, obsIns[2][6]}, 8'h01);
    applyStimulus(1'b0, 3'd0, 8'h40);
    step();
    checkValue("eoiack bit6 cleared", {7'd0, obsIns[2][6]}, 8'h00);
    checkValue("eoiack ack c2", obsAck[2], 8'h40);
    applyStimulus(1'b0, 3'd0, 8'd0);
    step();
    checkValue("eoiack ack c3", obsAck[2], 8'h40);
    step();
    checkValue("eoiack ack c4", obsAck[2], 8'h40);
    step();
    checkValue("eoiack ack fall", obsAck[2], 8'h00);

    // Random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd0);
      step();
    end
    rst = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
